// File: rtl/mio_bus_if.sv
// CPU-side memory/IO bus: the CPU drives address, write data and strobe;
// the bus returns combinational read data.
interface mio_bus_if;
   logic        mem_w;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;

   modport master (output mem_w, addr, wdata, input  rdata);
   modport slave  (input  mem_w, addr, wdata, output rdata);
endinterface

// File: rtl/mio_bus.sv
// Memory/IO bus behind the multicycle CPU: decodes RAM, display, GPIO and a
// down-counter timer that raises a one-cycle interrupt at terminal count.
module mio_bus #(
   parameter int          RAM_AW    = 10,
   parameter logic [31:0] SEG_RESET = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              reset,
   mio_bus_if.slave          cpu,
   output logic              ram_we,
   output logic [RAM_AW-1:0] ram_addr,
   output logic [31:0]       ram_wdata,
   input  logic [31:0]       ram_rdata,
   input  logic [15:0]       sw,
   input  logic [3:0]        btn,
   output logic [15:0]       led_out,
   output logic [31:0]       seg_out,
   output logic              timer_irq
);

   localparam logic [31:0] SEG_ADDR   = 32'hE000_0000;
   localparam logic [31:0] GPIO_ADDR  = 32'hF000_0000;
   localparam logic [31:0] TIMER_ADDR = 32'hF000_0004;

   typedef enum logic [1:0] {
      MODE_STOP     = 2'b00,
      MODE_ONESHOT  = 2'b01,
      MODE_PERIODIC = 2'b10,
      MODE_RSVD     = 2'b11
   } mode_e;

   logic sel_ram, sel_seg, sel_gpio, sel_timer;
   logic wr_seg, wr_gpio, wr_timer;

   mode_e       mode_q, mode_d;
   logic [31:0] count_q, count_d;
   logic [31:0] reload_q, reload_d;
   logic        sticky_q, sticky_d;
   logic        irq_d;
   logic        running;

   assign sel_ram   = (cpu.addr[31:16] == 16'h0000);
   assign sel_seg   = (cpu.addr == SEG_ADDR);
   assign sel_gpio  = (cpu.addr == GPIO_ADDR);
   assign sel_timer = (cpu.addr == TIMER_ADDR);

   assign wr_seg   = cpu.mem_w & sel_seg;
   assign wr_gpio  = cpu.mem_w & sel_gpio;
   assign wr_timer = cpu.mem_w & sel_timer;

   assign ram_we    = cpu.mem_w & sel_ram;
   assign ram_addr  = cpu.addr[RAM_AW+1:2];
   assign ram_wdata = cpu.wdata;

   // Reserved mode 11 behaves as stopped; a zero count never decrements.
   assign running = ((mode_q == MODE_ONESHOT) || (mode_q == MODE_PERIODIC)) &&
                    (count_q != 32'd0);

   always_comb begin
      // NOTE: every target gets a default first so no path leaves it unassigned (no latch).
      count_d  = count_q;
      reload_d = reload_q;
      mode_d   = mode_q;
      sticky_d = sticky_q;
      irq_d    = 1'b0;

      if (wr_timer) begin
         reload_d = cpu.wdata;
         count_d  = cpu.wdata;
      end else if (running) begin
         if (count_q == 32'd1) begin
            irq_d    = 1'b1;
            sticky_d = 1'b1;
            if (mode_q == MODE_PERIODIC) begin
               count_d = reload_q;
            end else begin
               count_d = 32'd0;
               mode_d  = MODE_STOP;
            end
         end else begin
            count_d = count_q - 32'd1;
         end
      end

      // A mode write overrides the one-shot auto-stop; a terminal count beats a sticky clear.
      if (wr_gpio) begin
         mode_d = mode_e'(cpu.wdata[17:16]);
         if (cpu.wdata[31] && !irq_d) sticky_d = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         led_out   <= 16'h0000;
         seg_out   <= SEG_RESET;
         mode_q    <= MODE_STOP;
         count_q   <= 32'd0;
         reload_q  <= 32'd0;
         sticky_q  <= 1'b0;
         timer_irq <= 1'b0;
      end else begin
         if (wr_gpio) led_out <= cpu.wdata[15:0];
         if (wr_seg)  seg_out <= cpu.wdata;
         mode_q    <= mode_d;
         count_q   <= count_d;
         reload_q  <= reload_d;
         sticky_q  <= sticky_d;
         timer_irq <= irq_d;
      end
   end

   always_comb begin
      cpu.rdata = 32'h0000_0000;
      if (sel_ram)        cpu.rdata = ram_rdata;
      else if (sel_seg)   cpu.rdata = seg_out;
      else if (sel_gpio)  cpu.rdata = {sticky_q, 9'b0, mode_q, btn, sw};
      else if (sel_timer) cpu.rdata = count_q;
   end

endmodule

// File: tb/tb_mio_bus.sv
// Bench for mio_bus: a behavioural model checked every cycle plus directed
// scenarios with hand-computed expectations.
module tb_mio_bus;

   localparam logic [31:0] SEG_A   = 32'hE000_0000;
   localparam logic [31:0] GPIO_A  = 32'hF000_0000;
   localparam logic [31:0] TIMER_A = 32'hF000_0004;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        ram_we;
   logic [9:0]  ram_addr;
   logic [31:0] ram_wdata;
   logic [31:0] ram_rdata;
   logic [15:0] sw = 16'h0000;
   logic [3:0]  btn = 4'h0;
   logic [15:0] led_out;
   logic [31:0] seg_out;
   logic        timer_irq;

   int n_checks = 0;
   int n_err    = 0;

   mio_bus_if bus ();

   mio_bus dut (
      .clk       (clk),
      .reset     (reset),
      .cpu       (bus.slave),
      .ram_we    (ram_we),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .ram_rdata (ram_rdata),
      .sw        (sw),
      .btn       (btn),
      .led_out   (led_out),
      .seg_out   (seg_out),
      .timer_irq (timer_irq)
   );

   always #5 clk = ~clk;

   // Physical RAM attached to the DUT's RAM port.
   logic [31:0] phys_ram [1024];
   assign ram_rdata = phys_ram[ram_addr];
   always @(posedge clk) if (ram_we) phys_ram[ram_addr] <= ram_wdata;

   // Behavioural model of the register file and timer.
   logic [31:0] m_ram [1024];
   logic [15:0] m_led;
   logic [31:0] m_seg, m_count, m_reload;
   logic [1:0]  m_mode;
   logic        m_sticky, m_irq;

   initial begin
      for (int i = 0; i < 1024; i++) begin
         phys_ram[i] = 32'h0;
         m_ram[i]    = 32'h0;
      end
   end

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_led = 16'h0; m_seg = 32'h0; m_mode = 2'b00;
         m_count = 32'h0; m_reload = 32'h0; m_sticky = 1'b0; m_irq = 1'b0;
      end else begin
         logic       fire;
         logic [1:0] old_mode;
         fire     = 1'b0;
         old_mode = m_mode;
         if (bus.mem_w && bus.addr[31:16] == 16'h0) m_ram[bus.addr[11:2]] = bus.wdata;
         if (bus.mem_w && bus.addr == SEG_A) m_seg = bus.wdata;
         if (bus.mem_w && bus.addr == TIMER_A) begin
            m_count  = bus.wdata;
            m_reload = bus.wdata;
         end else if ((old_mode == 2'b01 || old_mode == 2'b10) && m_count > 0) begin
            if (m_count == 1) begin
               fire     = 1'b1;
               m_sticky = 1'b1;
               m_count  = (old_mode == 2'b10) ? m_reload : 32'h0;
               if (old_mode == 2'b01) m_mode = 2'b00;
            end else begin
               m_count = m_count - 1;
            end
         end
         if (bus.mem_w && bus.addr == GPIO_A) begin
            m_led  = bus.wdata[15:0];
            m_mode = bus.wdata[17:16];
            if (bus.wdata[31] && !fire) m_sticky = 1'b0;
         end
         m_irq = fire;
      end
   end

   function automatic logic [31:0] m_read(input logic [31:0] a);
      if (a[31:16] == 16'h0) return m_ram[a[11:2]];
      if (a == SEG_A)        return m_seg;
      if (a == GPIO_A)       return {m_sticky, 9'b0, m_mode, btn, sw};
      if (a == TIMER_A)      return m_count;
      return 32'h0;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      check("led_out",   {16'h0, led_out}, {16'h0, m_led});
      check("seg_out",   seg_out, m_seg);
      check("timer_irq", {31'h0, timer_irq}, {31'h0, m_irq});
      check("cpu_rdata", bus.rdata, m_read(bus.addr));
      check("ram_we",    {31'h0, ram_we}, {31'h0, bus.mem_w && bus.addr[31:16] == 16'h0});
      check("ram_addr",  {22'h0, ram_addr}, {22'h0, bus.addr[11:2]});
      check("ram_wdata", ram_wdata, bus.wdata);
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      bus.mem_w = 1'b1;
      bus.addr  = a;
      bus.wdata = d;
      @(posedge clk);
      #1;
      bus.mem_w = 1'b0;
   endtask

   task automatic read_at(input logic [31:0] a);
      bus.addr = a;
      #1;
   endtask

   initial begin
      int irqs;
      bus.mem_w = 1'b0;
      bus.addr  = 32'h0;
      bus.wdata = 32'h0;
      #1 reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      read_at(TIMER_A);
      check("rst_led", {16'h0, led_out}, 32'h0);
      check("rst_seg", seg_out, 32'h0);
      check("rst_cnt", bus.rdata, 32'h0);

      // RAM path
      bus.mem_w = 1'b1; bus.addr = 32'h0000_0010; bus.wdata = 32'hDEAD_BEEF;
      #1;
      check("ram_we_hit",  {31'h0, ram_we}, 32'h1);
      check("ram_addr_4",  {22'h0, ram_addr}, 32'h4);
      check("ram_wdata_v", ram_wdata, 32'hDEAD_BEEF);
      @(posedge clk); #1;
      bus.mem_w = 1'b0;
      read_at(32'h0000_0010);
      check("ram_read", bus.rdata, 32'hDEAD_BEEF);
      bus.mem_w = 1'b1; bus.addr = 32'h0001_0000;
      #1;
      check("ram_we_miss", {31'h0, ram_we}, 32'h0);
      @(posedge clk); #1;
      bus.mem_w = 1'b0;

      // GPIO and display
      bus_write(GPIO_A, 32'h0002_00A5);
      bus_write(SEG_A,  32'h1234_5678);
      sw = 16'h8001; btn = 4'h3;
      read_at(GPIO_A);
      check("led_a5",   {16'h0, led_out}, 32'h0000_00A5);
      check("seg_val",  seg_out, 32'h1234_5678);
      check("gpio_rd",  bus.rdata, 32'h0023_8001);

      // Periodic timer, reload 3
      bus_write(GPIO_A, 32'h0000_0000);
      bus_write(TIMER_A, 32'd3);
      bus_write(GPIO_A, 32'h0002_0000);
      read_at(TIMER_A);
      check("per_c3", bus.rdata, 32'd3);
      idle(1); check("per_c2", bus.rdata, 32'd2);
      idle(1); check("per_c1", bus.rdata, 32'd1);
      check("per_noirq", {31'h0, timer_irq}, 32'h0);
      idle(1); check("per_irq", {31'h0, timer_irq}, 32'h1);
      check("per_reload", bus.rdata, 32'd3);
      irqs = 0;
      for (int i = 0; i < 9; i++) begin
         idle(1);
         if (timer_irq) irqs++;
      end
      check("per_irq_cnt", irqs, 32'd3);
      read_at(GPIO_A);
      check("sticky_set", {31'h0, bus.rdata[31]}, 32'h1);
      bus_write(GPIO_A, 32'h8000_0000);
      read_at(GPIO_A);
      check("sticky_clr", {31'h0, bus.rdata[31]}, 32'h0);
      check("mode_stop",  {30'h0, bus.rdata[21:20]}, 32'h0);

      // One-shot, reload 2
      bus_write(TIMER_A, 32'd2);
      bus_write(GPIO_A, 32'h0001_0000);
      read_at(TIMER_A);
      idle(1); check("os_c1", bus.rdata, 32'd1);
      idle(1); check("os_irq", {31'h0, timer_irq}, 32'h1);
      check("os_c0", bus.rdata, 32'd0);
      read_at(GPIO_A);
      check("os_mode0", {30'h0, bus.rdata[21:20]}, 32'h0);
      idle(3);
      read_at(TIMER_A);
      check("os_hold0", bus.rdata, 32'd0);

      // TIMER write colliding with terminal count
      bus_write(TIMER_A, 32'd3);
      bus_write(GPIO_A, 32'h8002_0000);
      idle(2);
      bus_write(TIMER_A, 32'd7);
      read_at(TIMER_A);
      check("col_noirq", {31'h0, timer_irq}, 32'h0);
      check("col_c7", bus.rdata, 32'd7);
      read_at(GPIO_A);
      check("col_sticky", {31'h0, bus.rdata[31]}, 32'h0);

      // Sticky clear on terminal edge: set wins
      bus_write(TIMER_A, 32'd2);
      idle(1);
      bus_write(GPIO_A, 32'h8002_0000);
      read_at(GPIO_A);
      check("setwin_irq", {31'h0, timer_irq}, 32'h1);
      check("setwin_sticky", {31'h0, bus.rdata[31]}, 32'h1);

      // Mode write on terminal edge: written mode wins, periodic reload still applies
      idle(1);
      bus_write(GPIO_A, 32'h0000_0000);
      read_at(TIMER_A);
      check("modewin_irq", {31'h0, timer_irq}, 32'h1);
      check("modewin_c2", bus.rdata, 32'd2);
      idle(2);
      check("modewin_hold", bus.rdata, 32'd2);

      // Periodic with reload 0 never fires
      bus_write(TIMER_A, 32'd0);
      bus_write(GPIO_A, 32'h0002_0000);
      irqs = 0;
      for (int i = 0; i < 5; i++) begin
         idle(1);
         if (timer_irq) irqs++;
      end
      check("zero_noirq", irqs, 32'd0);

      // Unmapped writes and reads
      bus_write(32'h8000_0000, 32'hFFFF_FFFF);
      bus_write(32'hE000_0004, 32'hFFFF_FFFF);
      bus_write(32'hF000_0008, 32'hFFFF_FFFF);
      read_at(32'h8000_0000);
      check("unmap_rd", bus.rdata, 32'h0);
      check("unmap_seg", seg_out, 32'h1234_5678);

      // Asynchronous reset mid-count
      bus_write(SEG_A, 32'hCAFE_0001);
      bus_write(TIMER_A, 32'd5);
      bus_write(GPIO_A, 32'h0002_00FF);
      read_at(TIMER_A);
      reset = 1'b1;
      #1;
      check("arst_led", {16'h0, led_out}, 32'h0);
      check("arst_seg", seg_out, 32'h0);
      check("arst_irq", {31'h0, timer_irq}, 32'h0);
      check("arst_cnt", bus.rdata, 32'h0);
      idle(2);
      reset = 1'b0;
      idle(4);
      check("post_rst_cnt", bus.rdata, 32'h0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
